// File: rtl/fetch_queue.sv
// fetch_queue: dual-issue fetch front end and in-order
// instruction queue presenting up to two entries to decode.
module fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stop_fetch,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  input  logic        fifo_rst,
  input  logic        fifo_stall,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata1,
  input  logic [31:0] imem_rdata2,
  output logic        fifo_full,
  output logic        valid1,
  output logic [31:0] pc1_out,
  output logic [31:0] instr1_out,
  output logic        valid2,
  output logic [31:0] pc2_out,
  output logic [31:0] instr2_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   r_pc;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_epc [DEPTH];
  logic [31:0]   r_ein [DEPTH];

  logic [CW-1:0] w_free;
  logic          w_full;
  logic          w_req;
  logic          w_pop_en;
  logic [1:0]    w_npush;
  logic [1:0]    w_npop;
  logic [AW-1:0] w_rd1;
  logic [AW-1:0] w_wr1;
  logic [31:0]   w_tgt;
  logic [31:0]   w_pc4;
  logic [31:0]   w_pc8;
  logic          w_v1;
  logic          w_v2;

  assign w_free   = CW'(DEPTH) - r_count;
  assign w_full   = w_free < CW'(2);
  assign w_req    = !stop_fetch && !w_full
                 && !jump && !fifo_rst;
  assign w_tgt    = jump_addr & 32'hFFFF_FFFC;
  assign w_pc4    = r_pc + 32'd4;
  assign w_pc8    = r_pc + 32'd8;
  // An odd-word pc only has the upper word of the pair left.
  assign w_npush  = !w_req   ? 2'd0
                  : r_pc[2]  ? 2'd1 : 2'd2;
  assign w_pop_en = !fifo_stall && !fifo_rst;
  assign w_npop   = !w_pop_en ? 2'd0
                  : (r_count >= CW'(2)) ? 2'd2
                  : r_count[1:0];
  assign w_rd1    = r_rd_ptr + AW'(1);
  assign w_wr1    = r_wr_ptr + AW'(1);

  // Entry storage; written only into free slots, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_npush != 2'd0) begin
      r_epc[r_wr_ptr] <= r_pc;
      r_ein[r_wr_ptr] <= r_pc[2] ? imem_rdata2
                                 : imem_rdata1;
    end
    if (w_npush == 2'd2) begin
      r_epc[w_wr1] <= w_pc4;
      r_ein[w_wr1] <= imem_rdata2;
    end
  end

  // Fetch pc, pointers and occupancy; flush/redirect take priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (jump)
        r_pc <= w_tgt;
      else if (w_req)
        r_pc <= r_pc[2] ? w_pc4 : w_pc8;
      if (fifo_rst) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_rd_ptr <= r_rd_ptr + AW'(w_npop);
        r_wr_ptr <= r_wr_ptr + AW'(w_npush);
        r_count  <= r_count + CW'(w_npush)
                  - CW'(w_npop);
      end
    end
  end

  assign w_v1 = r_count != '0;
  assign w_v2 = r_count >= CW'(2);

  assign imem_addr  = {r_pc[31:3], 3'b000};
  assign imem_req   = w_req;
  assign fifo_full  = w_full;
  assign valid1     = w_v1;
  assign valid2     = w_v2;
  assign pc1_out    = w_v1 ? r_epc[r_rd_ptr] : '0;
  assign instr1_out = w_v1 ? r_ein[r_rd_ptr] : '0;
  assign pc2_out    = w_v2 ? r_epc[w_rd1] : '0;
  assign instr2_out = w_v2 ? r_ein[w_rd1] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed + random checks of fetch_queue
// against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stop_fetch, jump, fifo_rst, fifo_stall;
  logic [31:0] jump_addr;
  logic [31:0] imem_addr, imem_rdata1, imem_rdata2;
  logic        imem_req, fifo_full, valid1, valid2;
  logic [31:0] pc1_out, instr1_out, pc2_out, instr2_out;

  always #5 clk = ~clk;

  assign imem_rdata1 = imem_addr ^ K;
  assign imem_rdata2 = (imem_addr + 32'd4) ^ K;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .stop_fetch(stop_fetch), .jump(jump),
    .jump_addr(jump_addr), .fifo_rst(fifo_rst),
    .fifo_stall(fifo_stall), .imem_addr(imem_addr),
    .imem_req(imem_req), .imem_rdata1(imem_rdata1),
    .imem_rdata2(imem_rdata2), .fifo_full(fifo_full),
    .valid1(valid1), .pc1_out(pc1_out),
    .instr1_out(instr1_out), .valid2(valid2),
    .pc2_out(pc2_out), .instr2_out(instr2_out)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pc;
  logic [31:0] mq_pc[$];
  logic [31:0] mq_in[$];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic bit m_full();
    return (DEPTH - mq_pc.size()) < 2;
  endfunction

  function automatic bit m_req();
    return !stop_fetch && !m_full() && !jump && !fifo_rst;
  endfunction

  task automatic m_check(string tag);
    logic [31:0] p1, i1, p2, i2;
    p1 = 0; i1 = 0; p2 = 0; i2 = 0;
    if (mq_pc.size() >= 1) begin
      p1 = mq_pc[0]; i1 = mq_in[0];
    end
    if (mq_pc.size() >= 2) begin
      p2 = mq_pc[1]; i2 = mq_in[1];
    end
    chk({tag, ".addr"}, imem_addr, {m_pc[31:3], 3'b000});
    chk({tag, ".req"}, 32'(imem_req), 32'(m_req()));
    chk({tag, ".full"}, 32'(fifo_full), 32'(m_full()));
    chk({tag, ".v1"}, 32'(valid1), 32'(mq_pc.size() >= 1));
    chk({tag, ".v2"}, 32'(valid2), 32'(mq_pc.size() >= 2));
    chk({tag, ".pc1"}, pc1_out, p1);
    chk({tag, ".in1"}, instr1_out, i1);
    chk({tag, ".pc2"}, pc2_out, p2);
    chk({tag, ".in2"}, instr2_out, i2);
  endtask

  task automatic step(string tag);
    bit req;
    int npop;
    #1;
    m_check(tag);
    req = m_req();
    @(posedge clk);
    if (fifo_rst) begin
      mq_pc.delete(); mq_in.delete();
    end else if (!fifo_stall) begin
      npop = mq_pc.size() < 2 ? mq_pc.size() : 2;
      repeat (npop) begin
        void'(mq_pc.pop_front());
        void'(mq_in.pop_front());
      end
    end
    if (req) begin
      mq_pc.push_back(m_pc);
      mq_in.push_back(m_pc ^ K);
      if (!m_pc[2]) begin
        mq_pc.push_back(m_pc + 4);
        mq_in.push_back((m_pc + 4) ^ K);
        m_pc = m_pc + 8;
      end else begin
        m_pc = m_pc + 4;
      end
    end
    if (jump) m_pc = jump_addr & 32'hFFFF_FFFC;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    stop_fetch = 0; jump = 0; fifo_rst = 0; fifo_stall = 0;
    jump_addr = 0;
    m_pc = 0;
    repeat (2) @(negedge clk);
    #1;
    m_check("reset");
    chk("reset.req", 32'(imem_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. fill
    fifo_stall = 1;
    repeat (4) step("fill");
    chk("fill.full", 32'(fifo_full), 32'd1);
    chk("fill.req", 32'(imem_req), 32'd0);
    chk("fill.addr", imem_addr, 32'h20);
    chk("fill.pc1", pc1_out, 32'h0);
    chk("fill.in1", instr1_out, 32'hA5A5_0000);
    chk("fill.pc2", pc2_out, 32'h4);

    // 2. drain
    fifo_stall = 0;
    step("drain");
    chk("drain.pc1a", pc1_out, 32'h8);
    chk("drain.full", 32'(fifo_full), 32'd0);
    step("drain");
    chk("drain.pc1b", pc1_out, 32'h10);
    repeat (3) step("drain");

    // 3. flush and redirect
    fifo_rst = 1; jump = 1; jump_addr = 32'h100;
    step("flush");
    fifo_rst = 0; jump = 0;
    chk("flush.v1", 32'(valid1), 32'd0);
    chk("flush.v2", 32'(valid2), 32'd0);
    chk("flush.addr", imem_addr, 32'h100);
    step("redir");
    chk("redir.pc1", pc1_out, 32'h100);
    chk("redir.pc2", pc2_out, 32'h104);

    // 4. odd-word target, queue empty
    stop_fetch = 1;
    repeat (5) step("empty");
    chk("empty.v1", 32'(valid1), 32'd0);
    stop_fetch = 0; jump = 1; jump_addr = 32'h10E;
    step("odd.jump");
    jump = 0;
    chk("odd.addr", imem_addr, 32'h108);
    step("odd.push");
    chk("odd.pc1", pc1_out, 32'h10C);
    chk("odd.in1", instr1_out, 32'hA5A5_010C);
    chk("odd.v2", 32'(valid2), 32'd0);
    chk("odd.next", imem_addr, 32'h110);

    // 5. stop_fetch with 4 entries queued
    fifo_rst = 1;
    step("s5.flush");
    fifo_rst = 0; fifo_stall = 1;
    repeat (2) step("s5.fill");
    fifo_stall = 0; stop_fetch = 1;
    step("s5.stop");
    chk("stop.v1a", 32'(valid1), 32'd1);
    chk("stop.pc1a", pc1_out, 32'h118);
    step("s5.stop");
    chk("stop.v1b", 32'(valid1), 32'd0);
    step("s5.stop");
    chk("stop.v1c", 32'(valid1), 32'd0);
    chk("stop.addr", imem_addr, 32'h120);
    stop_fetch = 0;
    step("s5.resume");
    chk("resume.pc1", pc1_out, 32'h120);

    // 6. async reset mid-fill
    fifo_rst = 1;
    step("s6.flush");
    fifo_rst = 0; fifo_stall = 1;
    repeat (3) step("s6.fill");
    chk("s6.v2", 32'(valid2), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    mq_pc.delete(); mq_in.delete();
    m_pc = 0;
    chk("arst.v1", 32'(valid1), 32'd0);
    chk("arst.pc1", pc1_out, 32'h0);
    chk("arst.in2", instr2_out, 32'h0);
    chk("arst.addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    fifo_stall = 0;
    step("arst.rel");
    chk("arst.pc1r", pc1_out, 32'h0);
    chk("arst.pc2r", pc2_out, 32'h4);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      stop_fetch = ($urandom_range(7) == 0);
      jump       = ($urandom_range(9) == 0);
      fifo_rst   = ($urandom_range(11) == 0);
      fifo_stall = ($urandom_range(3) == 0);
      jump_addr  = $urandom;
      step("rand");
    end
    stop_fetch = 0; jump = 0; fifo_rst = 0; fifo_stall = 0;
    step("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
